// File: rtl/systolic_mmu_os.sv
// systolic_mmu_os: output-stationary SIZExSIZE systolic matmul (C=AxB) with skew buffers, start/done control, valid/ready operand stream and row drain; ports: clk, reset(active-low sync), start/k_len/signed_mode, a_valid/a_ready/a_col/b_row, busy, out_valid/out_ready/out_row/out_row_idx/out_last, done
module systolic_mmu_os #(
  parameter int SIZE = 3,
  parameter int BIT_WIDTH = 8,
  parameter int ACC_WIDTH = 24,
  parameter int K_MAX = 16,
  parameter int KW = $clog2(K_MAX + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [KW-1:0]                 k_len,
  input  logic                          signed_mode,
  input  logic                          a_valid,
  output logic                          a_ready,
  input  logic [SIZE*BIT_WIDTH-1:0]     a_col,
  input  logic [SIZE*BIT_WIDTH-1:0]     b_row,
  output logic                          busy,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SIZE*ACC_WIDTH-1:0]     out_row,
  output logic [(SIZE>1 ? $clog2(SIZE) : 1)-1:0] out_row_idx,
  output logic                          out_last,
  output logic                          done
);
  localparam int RW = SIZE > 1 ? $clog2(SIZE) : 1;
  localparam int FW = $clog2(2 * SIZE + 1);
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;
  state_t state, nxt;
  logic [KW-1:0] k_lat, k_cnt;
  logic [FW-1:0] fl_cnt;
  logic [RW-1:0] r;
  logic sm, go, beat, last_beat, fl_end, drain_end, adv, clr;
  logic [BIT_WIDTH-1:0] a_w [SIZE][SIZE];
  logic [BIT_WIDTH-1:0] b_w [SIZE][SIZE];
  logic [ACC_WIDTH-1:0] acc [SIZE][SIZE];
  assign go = start && k_len != '0;
  assign beat = state == LOAD && a_valid;
  assign last_beat = beat && k_cnt == k_lat - 1'b1;
  assign fl_end = FW'(fl_cnt + 1'b1) == FW'(2 * SIZE - 2);
  assign drain_end = out_ready && r == RW'(SIZE - 1);
  // every beat and every flush cycle moves the whole array one step; otherwise it stalls
  assign adv = beat || state == FLUSH;
  assign clr = state == IDLE && go;
  assign a_ready = state == LOAD;
  assign busy = state != IDLE;
  assign out_valid = state == DRAIN;
  assign out_row_idx = r;
  assign out_last = state == DRAIN && r == RW'(SIZE - 1);
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = go ? LOAD : IDLE;
      LOAD:    nxt = last_beat ? (SIZE == 1 ? DRAIN : FLUSH) : LOAD;
      FLUSH:   nxt = fl_end ? DRAIN : FLUSH;
      DRAIN:   nxt = drain_end ? IDLE : DRAIN;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      k_lat <= '0;
      k_cnt <= '0;
      fl_cnt <= '0;
      r <= '0;
      sm <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= nxt;
      done <= state == DRAIN && drain_end;
      if (clr) begin
        k_lat <= k_len > KW'(K_MAX) ? KW'(K_MAX) : k_len;
        sm <= signed_mode;
      end
      k_cnt <= state == LOAD ? k_cnt + KW'(beat) : '0;
      fl_cnt <= state == FLUSH ? fl_cnt + 1'b1 : '0;
      r <= state == DRAIN ? (out_ready ? r + 1'b1 : r) : '0;
    end
  end
  genvar i, j;
  for (i = 0; i < SIZE; i++) begin : g_skew
    logic [BIT_WIDTH-1:0] a_inj, b_inj;
    // zeros enter the skew chains during flush
    assign a_inj = state == LOAD ? a_col[i*BIT_WIDTH +: BIT_WIDTH] : '0;
    assign b_inj = state == LOAD ? b_row[i*BIT_WIDTH +: BIT_WIDTH] : '0;
    if (i == 0) begin : g_direct
      assign a_w[0][0] = a_inj;
      assign b_w[0][0] = b_inj;
    end else begin : g_delay
      logic [BIT_WIDTH-1:0] sa [i];
      logic [BIT_WIDTH-1:0] sb [i];
      always_ff @(posedge clk) begin
        if (!reset || clr) begin
          sa <= '{default: '0};
          sb <= '{default: '0};
        end else if (adv) begin
          sa[0] <= a_inj;
          sb[0] <= b_inj;
          for (int d = 1; d < i; d++) begin
            sa[d] <= sa[d-1];
            sb[d] <= sb[d-1];
          end
        end
      end
      assign a_w[i][0] = sa[i-1];
      assign b_w[0][i] = sb[i-1];
    end
  end
  for (i = 0; i < SIZE; i++) begin : g_row
    for (j = 0; j < SIZE; j++) begin : g_pe
      logic [ACC_WIDTH-1:0] ea, eb;
      // extending operands to the accumulator width yields the wrapped signed/unsigned product directly
      assign ea = {{(ACC_WIDTH-BIT_WIDTH){sm & a_w[i][j][BIT_WIDTH-1]}}, a_w[i][j]};
      assign eb = {{(ACC_WIDTH-BIT_WIDTH){sm & b_w[i][j][BIT_WIDTH-1]}}, b_w[i][j]};
      always_ff @(posedge clk) begin
        if (!reset || clr) acc[i][j] <= '0;
        else if (adv) acc[i][j] <= acc[i][j] + ea * eb;
      end
      if (j > 0) begin : g_a
        always_ff @(posedge clk) begin
          if (!reset || clr) a_w[i][j] <= '0;
          else if (adv) a_w[i][j] <= a_w[i][j-1];
        end
      end
      if (i > 0) begin : g_b
        always_ff @(posedge clk) begin
          if (!reset || clr) b_w[i][j] <= '0;
          else if (adv) b_w[i][j] <= b_w[i-1][j];
        end
      end
    end
  end
  always_comb begin
    out_row = '0;
    for (int c = 0; c < SIZE; c++) out_row[c*ACC_WIDTH +: ACC_WIDTH] = acc[r][c];
  end
endmodule

// File: tb/tb_systolic_mmu_os.sv
// tb_systolic_mmu_os: randomized self-checking bench for systolic_mmu_os against an arithmetic matrix-product model
module tb_systolic_mmu_os;
  localparam int S = 3, BW = 8, KM = 16, KW = 5;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, signed_mode = 1'b0, a_valid = 1'b0, out_ready = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic [S*BW-1:0] a_col = '0, b_row = '0;
  logic a_ready, busy, out_valid, out_last, done;
  logic [S*24-1:0] out_row;
  logic [1:0] out_row_idx;
  logic a_ready_w, busy_w, out_valid_w, out_last_w, done_w;
  logic [S*16-1:0] out_row_w;
  logic [1:0] out_row_idx_w;
  int n_cmp = 0, n_err = 0;
  logic [BW-1:0] ma [S][KM];
  logic [BW-1:0] mb [KM][S];
  always #5 clk = ~clk;
  systolic_mmu_os #(.SIZE(S), .BIT_WIDTH(BW), .ACC_WIDTH(24), .K_MAX(KM)) dut (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len), .signed_mode(signed_mode),
    .a_valid(a_valid), .a_ready(a_ready), .a_col(a_col), .b_row(b_row), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_row_idx(out_row_idx),
    .out_last(out_last), .done(done));
  systolic_mmu_os #(.SIZE(S), .BIT_WIDTH(BW), .ACC_WIDTH(16), .K_MAX(KM)) dut_w (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len), .signed_mode(signed_mode),
    .a_valid(a_valid), .a_ready(a_ready_w), .a_col(a_col), .b_row(b_row), .busy(busy_w),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_row(out_row_w), .out_row_idx(out_row_idx_w),
    .out_last(out_last_w), .done(done_w));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic longint expc(input int i, input int j, input int k, input bit sm);
    longint s = 0;
    for (int kk = 0; kk < k; kk++) begin
      longint x = ma[i][kk];
      longint y = mb[kk][j];
      if (sm && x > 127) x -= 256;
      if (sm && y > 127) y -= 256;
      s += x * y;
    end
    return s;
  endfunction
  task automatic fill(input int dmode);
    for (int k = 0; k < KM; k++)
      for (int i = 0; i < S; i++) begin
        ma[i][k] = dmode == 0 ? BW'($urandom) : dmode == 1 ? BW'(i == k) : dmode == 2 ? 8'hFF : 8'd255;
        mb[k][i] = dmode == 0 ? BW'($urandom) : dmode == 1 ? (k < S ? BW'(k * S + i + 1) : 8'd0) : dmode == 2 ? 8'd2 : 8'd255;
      end
  endtask
  task automatic run_job(input int kreq, input bit sm, input int vmode, input bit bp, input bit tail);
    int k, beat, n;
    longint e;
    bit pat [7] = '{1, 0, 0, 1, 0, 1, 1};
    k = kreq > KM ? KM : kreq;
    beat = 0;
    n = 0;
    start = 1'b1;
    k_len = KW'(kreq);
    signed_mode = sm;
    step;
    start = 1'b0;
    signed_mode = 1'($urandom);
    k_len = KW'($urandom);
    chk("busy_load", busy, 1);
    while (beat < k && n < 200) begin
      a_valid = vmode == 0 ? 1'b1 : vmode == 1 ? (n < 7 ? pat[n] : 1'b1) : 1'($urandom);
      for (int i = 0; i < S; i++) begin
        a_col[i*BW +: BW] = a_valid ? ma[i][beat] : BW'($urandom);
        b_row[i*BW +: BW] = a_valid ? mb[beat][i] : BW'($urandom);
      end
      chk("a_ready", a_ready, 1);
      step;
      if (a_valid) beat++;
      n++;
    end
    chk("beats", beat, k);
    chk("a_ready_off", a_ready, 0);
    chk("a_ready_off_w", a_ready_w, 0);
    a_valid = 1'($urandom);
    a_col = 24'($urandom);
    b_row = 24'($urandom);
    n = 0;
    while (!out_valid && n < 50) begin
      step;
      n++;
    end
    chk("latency", n, 2 * S - 2);
    for (int r = 0; r < S; r++) begin
      n = 0;
      do begin
        out_ready = bp ? (r == 1 ? n >= 3 : 1'($urandom)) : 1'b1;
        chk("valid", out_valid, 1);
        chk("valid_w", out_valid_w, 1);
        chk("idx", out_row_idx, r);
        chk("idx_w", out_row_idx_w, r);
        chk("last", out_last, r == S - 1);
        chk("last_w", out_last_w, r == S - 1);
        chk("done_early", done, 0);
        for (int j = 0; j < S; j++) begin
          e = expc(r, j, k, sm);
          chk("row", out_row[j*24 +: 24], 64'(e) & 64'hFFFFFF);
          chk("row_w", out_row_w[j*16 +: 16], 64'(e) & 64'hFFFF);
        end
        step;
        n++;
      end while (!out_ready && n < 50);
    end
    out_ready = 1'b0;
    chk("done", done, 1);
    chk("done_w", done_w, 1);
    chk("busy_end", busy, 0);
    chk("busy_end_w", busy_w, 0);
    chk("valid_end", out_valid, 0);
    if (tail) begin
      step;
      chk("done_pulse", done, 0);
    end
  endtask
  initial begin
    step;
    step;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", a_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_row_nz", 64'(out_row != '0), 0);
    chk("rst_idx", out_row_idx, 0);
    chk("rst_last", out_last, 0);
    reset = 1'b1;
    step;
    fill(1); run_job(3, 0, 0, 0, 1);
    fill(2); run_job(2, 1, 0, 0, 1);
    run_job(2, 0, 0, 0, 1);
    fill(0); run_job(4, 0, 1, 0, 1);
    fill(0); run_job(3, 1, 0, 1, 1);
    fill(3); run_job(20, 0, 0, 0, 1);
    fill(0);
    start = 1'b1;
    k_len = 5'd3;
    step;
    start = 1'b0;
    a_valid = 1'b1;
    a_col = 24'hFFFFFF;
    b_row = 24'hFFFFFF;
    repeat (4) step;
    chk("flush_busy", busy, 1);
    chk("flush_ready", a_ready, 0);
    reset = 1'b0;
    a_valid = 1'b0;
    step;
    reset = 1'b1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    repeat (8) begin
      step;
      chk("abort_idle_done", done, 0);
      chk("abort_idle_valid", out_valid, 0);
    end
    start = 1'b1;
    k_len = '0;
    step;
    start = 1'b0;
    chk("k0_busy", busy, 0);
    step;
    chk("k0_busy2", busy, 0);
    chk("k0_done", done, 0);
    fill(0); run_job(5, 1, 2, 1, 0);
    fill(0); run_job(3, 0, 2, 1, 1);
    fill(0); run_job(16, 1, 2, 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
